// File: rtl/ex_stage_pkg.sv
// Shared opcodes, result-class codes and widths for the execute stage.
package ex_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned ALUSEL_W   = 3;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned STALL_W    = 6;
    localparam int unsigned STALL_EX   = 3;

    localparam logic [DATA_W-1:0]     ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] EX_NOP_OP    = 8'h00;
    localparam logic [ALUOP_W-1:0] EX_AND_OP    = 8'h01;
    localparam logic [ALUOP_W-1:0] EX_OR_OP     = 8'h02;
    localparam logic [ALUOP_W-1:0] EX_XOR_OP    = 8'h03;
    localparam logic [ALUOP_W-1:0] EX_SLL_OP    = 8'h04;
    localparam logic [ALUOP_W-1:0] EX_SRL_OP    = 8'h05;
    localparam logic [ALUOP_W-1:0] EX_SRA_OP    = 8'h06;
    localparam logic [ALUOP_W-1:0] EX_ADD_OP    = 8'h07;
    localparam logic [ALUOP_W-1:0] EX_SUB_OP    = 8'h08;
    localparam logic [ALUOP_W-1:0] EX_SLT_OP    = 8'h09;
    localparam logic [ALUOP_W-1:0] EX_SLTU_OP   = 8'h0A;
    localparam logic [ALUOP_W-1:0] EX_MUL_OP    = 8'h10;
    localparam logic [ALUOP_W-1:0] EX_MULH_OP   = 8'h11;
    localparam logic [ALUOP_W-1:0] EX_MULHSU_OP = 8'h12;
    localparam logic [ALUOP_W-1:0] EX_MULHU_OP  = 8'h13;
    localparam logic [ALUOP_W-1:0] EX_DIV_OP    = 8'h14;
    localparam logic [ALUOP_W-1:0] EX_DIVU_OP   = 8'h15;
    localparam logic [ALUOP_W-1:0] EX_REM_OP    = 8'h16;
    localparam logic [ALUOP_W-1:0] EX_REMU_OP   = 8'h17;
    localparam logic [ALUOP_W-1:0] EX_BEQ_OP    = 8'h20;
    localparam logic [ALUOP_W-1:0] EX_BNE_OP    = 8'h21;
    localparam logic [ALUOP_W-1:0] EX_BLT_OP    = 8'h22;
    localparam logic [ALUOP_W-1:0] EX_BGE_OP    = 8'h23;
    localparam logic [ALUOP_W-1:0] EX_BLTU_OP   = 8'h24;
    localparam logic [ALUOP_W-1:0] EX_BGEU_OP   = 8'h25;
    localparam logic [ALUOP_W-1:0] EX_JAL_OP    = 8'h26;
    localparam logic [ALUOP_W-1:0] EX_JALR_OP   = 8'h27;
    localparam logic [ALUOP_W-1:0] EX_LW_OP     = 8'h30;
    localparam logic [ALUOP_W-1:0] EX_SW_OP     = 8'h31;

    // Result classes
    localparam logic [ALUSEL_W-1:0] EX_RES_NOP         = 3'd0;
    localparam logic [ALUSEL_W-1:0] EX_RES_LOGIC       = 3'd1;
    localparam logic [ALUSEL_W-1:0] EX_RES_SHIFT       = 3'd2;
    localparam logic [ALUSEL_W-1:0] EX_RES_ARITH       = 3'd3;
    localparam logic [ALUSEL_W-1:0] EX_RES_MUL         = 3'd4;
    localparam logic [ALUSEL_W-1:0] EX_RES_DIV         = 3'd5;
    localparam logic [ALUSEL_W-1:0] EX_RES_JUMP_BRANCH = 3'd6;
    localparam logic [ALUSEL_W-1:0] EX_RES_LOAD_STORE  = 3'd7;

    // True for the four RV32M divide/remainder opcodes
    function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
        return (op == EX_DIV_OP) || (op == EX_DIVU_OP) ||
               (op == EX_REM_OP) || (op == EX_REMU_OP);
    endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle.
module ex_divider
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic              op_rem,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    div_state_e        state, state_nxt;
    logic [DATA_W-1:0] quo, rem, dsr, result_q;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q, neg_r, rem_sel;

    logic [DATA_W-1:0] abs_a, abs_b, quo_n, rem_n, q_fix, r_fix;
    logic [DATA_W:0]   rem_sh, diff;
    logic              div_zero, div_ovf, ge;

    assign abs_a    = (is_signed && a[DATA_W-1]) ? (~a + 32'd1) : a;
    assign abs_b    = (is_signed && b[DATA_W-1]) ? (~b + 32'd1) : b;
    assign div_zero = (b == ZERO_WORD);
    assign div_ovf  = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // One restoring shift/subtract step on the current partial remainder
    assign rem_sh = {rem, quo[DATA_W-1]};
    assign diff   = rem_sh - {1'b0, dsr};
    assign ge     = ~diff[DATA_W];
    assign rem_n  = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign quo_n  = {quo[DATA_W-2:0], ge};
    assign q_fix  = neg_q ? (~quo_n + 32'd1) : quo_n;
    assign r_fix  = neg_r ? (~rem_n + 32'd1) : rem_n;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = (div_zero || div_ovf) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (cnt == '0) state_nxt = DIV_DONE;
            DIV_DONE: if (!hold) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // Operand capture, iteration and sign fix-up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo      <= '0;
            rem      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rem_sel  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        quo     <= abs_a;
                        rem     <= '0;
                        dsr     <= abs_b;
                        cnt     <= CNT_W'(DIV_ITERS - 1);
                        neg_q   <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                        neg_r   <= is_signed & a[DATA_W-1];
                        rem_sel <= op_rem;
                        if (div_zero)     result_q <= op_rem ? a : 32'hFFFF_FFFF;
                        else if (div_ovf) result_q <= op_rem ? ZERO_WORD : 32'h8000_0000;
                    end
                end
                DIV_BUSY: begin
                    quo <= quo_n;
                    rem <= rem_n;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) result_q <= rem_sel ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == DIV_BUSY) || ((state == DIV_IDLE) && start);
    assign done   = (state == DIV_DONE);
    assign result = result_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/branch unit plus iterative divider with stall request.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [ALUSEL_W-1:0]   ex_alusel,
    input  logic [DATA_W-1:0]     ex_r1_data,
    input  logic [DATA_W-1:0]     ex_r2_data,
    input  logic [DATA_W-1:0]     ex_pc,
    input  logic [DATA_W-1:0]     ex_offset,
    input  logic                  ex_w_enable,
    input  logic [REG_ADDR_W-1:0] ex_w_addr,
    input  logic [STALL_W-1:0]    stall,
    output logic                  w_enable,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0]     w_data,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  ex_b_flag,
    output logic [DATA_W-1:0]     ex_b_target,
    output logic                  stallreq
);

    logic [DATA_W-1:0]   r1, r2, sum_addr, br_target, pc_plus4;
    logic [DATA_W-1:0]   logic_res, shift_res, arith_res, mul_res, div_result;
    logic [2*DATA_W-1:0] prod_ss, prod_su, prod_uu;
    logic [4:0]          shamt;
    logic                lt_s, lt_u, eq, br_taken;
    logic                div_busy, div_done, div_signed, div_rem;
    logic                unused_bits;

    assign r1        = ex_r1_data;
    assign r2        = ex_r2_data;
    assign shamt     = r2[4:0];
    assign sum_addr  = r1 + ex_offset;
    assign br_target = ex_pc + ex_offset;
    assign pc_plus4  = ex_pc + 32'd4;
    assign lt_s      = $signed(r1) < $signed(r2);
    assign lt_u      = r1 < r2;
    assign eq        = r1 == r2;

    // Sign/zero-extended 64-bit products for MUL and the MULH family
    assign prod_ss = {{DATA_W{r1[DATA_W-1]}}, r1} * {{DATA_W{r2[DATA_W-1]}}, r2};
    assign prod_su = {{DATA_W{r1[DATA_W-1]}}, r1} * {{DATA_W{1'b0}}, r2};
    assign prod_uu = {{DATA_W{1'b0}}, r1} * {{DATA_W{1'b0}}, r2};

    assign unused_bits = ^{prod_ss[DATA_W-1:0], prod_su[DATA_W-1:0],
                           stall[STALL_W-1:STALL_EX+1], stall[STALL_EX-1:0]};

    assign div_signed = (ex_aluop == EX_DIV_OP) || (ex_aluop == EX_REM_OP);
    assign div_rem    = (ex_aluop == EX_REM_OP) || (ex_aluop == EX_REMU_OP);

    ex_divider #(
        .DIV_ITERS (DIV_ITERS)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div_op(ex_aluop)),
        .is_signed (div_signed),
        .op_rem    (div_rem),
        .a         (r1),
        .b         (r2),
        .hold      (stall[STALL_EX]),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_result)
    );

    // Per-class ALU results and branch condition
    always_comb begin
        logic_res = ZERO_WORD;
        shift_res = ZERO_WORD;
        arith_res = ZERO_WORD;
        mul_res   = ZERO_WORD;
        br_taken  = 1'b0;
        case (ex_aluop)
            EX_AND_OP:    logic_res = r1 & r2;
            EX_OR_OP:     logic_res = r1 | r2;
            EX_XOR_OP:    logic_res = r1 ^ r2;
            EX_SLL_OP:    shift_res = r1 << shamt;
            EX_SRL_OP:    shift_res = r1 >> shamt;
            EX_SRA_OP:    shift_res = $signed(r1) >>> shamt;
            EX_ADD_OP:    arith_res = r1 + r2;
            EX_SUB_OP:    arith_res = r1 - r2;
            EX_SLT_OP:    arith_res = 32'(lt_s);
            EX_SLTU_OP:   arith_res = 32'(lt_u);
            EX_MUL_OP:    mul_res   = prod_uu[DATA_W-1:0];
            EX_MULH_OP:   mul_res   = prod_ss[2*DATA_W-1:DATA_W];
            EX_MULHSU_OP: mul_res   = prod_su[2*DATA_W-1:DATA_W];
            EX_MULHU_OP:  mul_res   = prod_uu[2*DATA_W-1:DATA_W];
            EX_BEQ_OP:    br_taken  = eq;
            EX_BNE_OP:    br_taken  = ~eq;
            EX_BLT_OP:    br_taken  = lt_s;
            EX_BGE_OP:    br_taken  = ~lt_s;
            EX_BLTU_OP:   br_taken  = lt_u;
            EX_BGEU_OP:   br_taken  = ~lt_u;
            default: ;
        endcase
    end

    // Output muxing; bubbles and reset drive every output to zero
    always_comb begin
        w_enable    = 1'b0;
        w_addr      = NOP_REG_ADDR;
        w_data      = ZERO_WORD;
        mem_aluop   = EX_NOP_OP;
        mem_addr    = ZERO_WORD;
        mem_wdata   = ZERO_WORD;
        ex_b_flag   = 1'b0;
        ex_b_target = ZERO_WORD;
        stallreq    = 1'b0;
        if (rst && (ex_aluop != EX_NOP_OP)) begin
            mem_aluop = ex_aluop;
            mem_addr  = sum_addr;
            mem_wdata = r2;
            w_addr    = ex_w_addr;
            w_enable  = ex_w_enable;
            case (ex_alusel)
                EX_RES_LOGIC: w_data = logic_res;
                EX_RES_SHIFT: w_data = shift_res;
                EX_RES_ARITH: w_data = arith_res;
                EX_RES_MUL:   w_data = mul_res;
                EX_RES_DIV: begin
                    stallreq = div_busy;
                    w_enable = ex_w_enable & div_done;
                    w_data   = div_done ? div_result : ZERO_WORD;
                end
                EX_RES_JUMP_BRANCH: begin
                    ex_b_flag = 1'b1;
                    case (ex_aluop)
                        EX_JAL_OP: begin
                            ex_b_target = br_target;
                            w_data      = pc_plus4;
                        end
                        EX_JALR_OP: begin
                            ex_b_target = sum_addr & ~32'd1;
                            w_data      = pc_plus4;
                        end
                        default: begin
                            ex_b_flag   = br_taken;
                            ex_b_target = br_target;
                            w_enable    = 1'b0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
